// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// data-memory wait handling with a timeout into a sticky ERROR state.
module pipe_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_pause,
    output logic             if_pause,
    output logic             if_bubble,
    output logic             id_pause,
    output logic             id_bubble,
    output logic             ex_pause,
    output logic             ex_bubble,
    output logic             mem_pause,
    output logic             mem_bubble,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          mem_stall;
    logic          load_use;
    logic          in_err;
    logic          br_apply;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));
    assign in_err    = (cur == ERROR);
    assign br_apply  = ~in_err & ~mem_stall & ex_branch_taken;

    assign state = cur;
    assign err   = in_err;

    always_comb begin
        pc_pause   = 1'b0;
        if_pause   = 1'b0;
        if_bubble  = 1'b0;
        id_pause   = 1'b0;
        id_bubble  = 1'b0;
        ex_pause   = 1'b0;
        ex_bubble  = 1'b0;
        mem_pause  = 1'b0;
        mem_bubble = 1'b0;
        if (in_err) begin
            pc_pause  = 1'b1;
            if_pause  = 1'b1;
            id_pause  = 1'b1;
            ex_pause  = 1'b1;
            mem_pause = 1'b1;
        end else if (mem_stall) begin
            pc_pause   = 1'b1;
            if_pause   = 1'b1;
            id_pause   = 1'b1;
            ex_pause   = 1'b1;
            mem_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // PC stays free so it loads the branch target
            if_bubble = 1'b1;
            id_bubble = 1'b1;
        end else if (load_use) begin
            pc_pause  = 1'b1;
            if_pause  = 1'b1;
            id_bubble = 1'b1;
        end
    end

    always_comb begin
        nxt      = cur;
        wait_nxt = wait_cnt;
        case (cur)
            RUN: begin
                wait_nxt = '0;
                if (mem_stall) nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    nxt      = RUN;
                    wait_nxt = '0;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                    if (wait_cnt == LAST) nxt = ERROR;
                end
            end
            ERROR:   nxt = ERROR;
            default: nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= RUN;
            wait_cnt <= '0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Counters saturate and are frozen once the block is in ERROR
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!in_err) begin
            if (pc_pause && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_apply && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance and a small
// instance (CNT_W=2, MEM_TIMEOUT=4) share one stimulus stream.
module tb_pipe_ctrl;

    logic       clock;
    logic       reset_n;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;

    logic        pc_p_a, if_p_a, if_b_a, id_p_a, id_b_a;
    logic        ex_p_a, ex_b_a, mem_p_a, mem_b_a;
    logic [1:0]  state_a;
    logic        err_a;
    logic [15:0] stall_a, flush_a;

    logic        pc_p_b, if_p_b, if_b_b, id_p_b, id_b_b;
    logic        ex_p_b, ex_b_b, mem_p_b, mem_b_b;
    logic [1:0]  state_b;
    logic        err_b;
    logic [1:0]  stall_b, flush_b;

    logic [8:0] pz_a, pz_b;

    int checks   = 0;
    int failures = 0;

    // {pc_p, if_p, if_b, id_p, id_b, ex_p, ex_b, mem_p, mem_b}
    localparam logic [8:0] P_NONE = 9'b000000000;
    localparam logic [8:0] P_LU   = 9'b110010000;
    localparam logic [8:0] P_BR   = 9'b001010000;
    localparam logic [8:0] P_MS   = 9'b110101001;
    localparam logic [8:0] P_ERR  = 9'b110101010;

    assign pz_a = {pc_p_a, if_p_a, if_b_a, id_p_a, id_b_a,
                   ex_p_a, ex_b_a, mem_p_a, mem_b_a};
    assign pz_b = {pc_p_b, if_p_b, if_b_b, id_p_b, id_b_b,
                   ex_p_b, ex_b_b, mem_p_b, mem_b_b};

    pipe_ctrl u_a (
        .clock(clock), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_pause(pc_p_a), .if_pause(if_p_a), .if_bubble(if_b_a),
        .id_pause(id_p_a), .id_bubble(id_b_a),
        .ex_pause(ex_p_a), .ex_bubble(ex_b_a),
        .mem_pause(mem_p_a), .mem_bubble(mem_b_a),
        .state(state_a), .err(err_a),
        .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) u_b (
        .clock(clock), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_pause(pc_p_b), .if_pause(if_p_b), .if_bubble(if_b_b),
        .id_pause(id_p_b), .id_bubble(id_b_b),
        .ex_pause(ex_p_b), .ex_bubble(ex_b_b),
        .mem_pause(mem_p_b), .mem_bubble(mem_b_b),
        .state(state_b), .err(err_b),
        .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;
        id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
        ex_rd = 5'd0;
        ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #2;
        chk("rst_state", 32'(state_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_stall", 32'(stall_a), 32'd0);
        chk("rst_flush", 32'(flush_a), 32'd0);
        chk("rst_pz_idle", 32'(pz_a), 32'(P_NONE));
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        #1;
        chk("rst_pz_lu", 32'(pz_a), 32'(P_LU));
        edge1();
        chk("rst_hold_stall", 32'(stall_a), 32'd0);
        idle();
        reset_n = 1'b1;

        // load-use through rs2
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        #1;
        chk("lu_pz", 32'(pz_a), 32'(P_LU));
        edge1();
        chk("lu_stall", 32'(stall_a), 32'd1);
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        chk("lu_x0_pz", 32'(pz_a), 32'(P_NONE));
        edge1();
        chk("lu_x0_stall", 32'(stall_a), 32'd1);

        // load-use through rs1, then qualifier off
        ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        id_use_rs2 = 1'b0; id_rs2 = 5'd7;
        #1;
        chk("lu1_pz", 32'(pz_a), 32'(P_LU));
        edge1();
        chk("lu1_stall", 32'(stall_a), 32'd2);
        id_use_rs1 = 1'b0;
        #1;
        chk("lu_unq_pz", 32'(pz_a), 32'(P_NONE));
        edge1();
        chk("lu_unq_stall", 32'(stall_a), 32'd2);

        // branch coinciding with load-use, then alone
        id_use_rs1 = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("br_lu_pz", 32'(pz_a), 32'(P_BR));
        edge1();
        chk("br_flush", 32'(flush_a), 32'd1);
        chk("br_stall", 32'(stall_a), 32'd2);
        ex_mem_read = 1'b0;
        #1;
        chk("br2_pz", 32'(pz_a), 32'(P_BR));
        edge1();
        chk("br2_flush", 32'(flush_a), 32'd2);

        // async reset mid-cycle clears counters
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_stall", 32'(stall_a), 32'd0);
        chk("arst_flush", 32'(flush_a), 32'd0);
        reset_n = 1'b1;
        edge1();

        // memory wait: 3 stalled cycles then ready
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("mw1_pz", 32'(pz_a), 32'(P_MS));
        edge1();
        chk("mw1_state", 32'(state_a), 32'd1);
        ex_branch_taken = 1'b1;
        #1;
        chk("mw2_pz_prio", 32'(pz_a), 32'(P_MS));
        edge1();
        chk("mw2_flush", 32'(flush_a), 32'd0);
        ex_branch_taken = 1'b0;
        #1;
        chk("mw3_pz", 32'(pz_a), 32'(P_MS));
        edge1();
        chk("mw3_state", 32'(state_a), 32'd1);
        chk("mw3_stall", 32'(stall_a), 32'd3);
        mem_ready = 1'b1;
        #1;
        chk("mw_rdy_pz", 32'(pz_a), 32'(P_NONE));
        edge1();
        chk("mw_run", 32'(state_a), 32'd0);
        chk("mw_stall_end", 32'(stall_a), 32'd3);
        chk("mw_b_run", 32'(state_b), 32'd0);

        // timeout on the small instance
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        mem_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            edge1();
            chk($sformatf("to_state_%0d", i), 32'(state_b),
                (i < 5) ? 32'd1 : 32'd2);
        end
        chk("to_err", 32'(err_b), 32'd1);
        chk("to_pz", 32'(pz_b), 32'(P_ERR));
        chk("to_stall_sat", 32'(stall_b), 32'd3);
        mem_req = 1'b0; ex_branch_taken = 1'b1;
        #1;
        chk("err_pz_hold", 32'(pz_b), 32'(P_ERR));
        edge1();
        chk("err_sticky", 32'(state_b), 32'd2);
        chk("err_flush_hold", 32'(flush_b), 32'd0);
        chk("a_not_err", 32'(err_a), 32'd0);

        // async reset while in ERROR
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rerr_state", 32'(state_b), 32'd0);
        chk("rerr_err", 32'(err_b), 32'd0);
        chk("rerr_stall", 32'(stall_b), 32'd0);
        chk("rerr_flush", 32'(flush_b), 32'd0);
        reset_n = 1'b1;
        edge1();

        // saturation: 5 load-use cycles on a 2-bit counter
        ex_mem_read = 1'b1; ex_rd = 5'd9;
        id_use_rs1 = 1'b1; id_rs1 = 5'd9;
        for (int i = 1; i <= 5; i++) begin
            edge1();
            chk($sformatf("sat_b_%0d", i), 32'(stall_b),
                (i < 3) ? 32'(i) : 32'd3);
        end
        chk("sat_a", 32'(stall_a), 32'd5);
        idle();
        edge1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
